lut_cell_using_mux: RTL
=======================

# lut_cell_using_mux

Registered, multi-lane programmable logic cell. Each lane evaluates an arbitrary K-input Boolean function through a 2:1 mux tree indexed by that lane's inputs. The truth table is shared by all lanes and is loaded serially at run time, so the AND/OR/XOR cells in the combinational library become one reusable sequential block. It sits between upstream data producers and consumers, which it couples with a valid-qualified one-stage pipeline.

## Interface

Parameters:
- K, default 2: inputs per lane; truth table depth N = 2^K entries; legal range 1..6.
- W, default 4: number of independent lanes sharing one truth table.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- cfg_load, input, 1: shift one truth-table bit in this cycle.
- cfg_bit, input, 1: bit shifted in when cfg_load=1.
- cfg_done, output, 1: high while the table is complete and the cell accepts data.
- in_valid, input, 1: in_data is valid this cycle.
- in_data, input, W*K: lane j inputs at in_data[j*K +: K]; index bit 0 selects at the first mux level.
- out_valid, output, 1: out_data is valid this cycle.
- out_data, output, W: bit j = table[in_data lane j] of the accepted beat.

## Operation

- Internal state: table[N-1:0], load counter cnt (width $clog2(N+1)), and state.
- States:
  - UNCONF: no valid table.
  - LOADING: cnt < N bits received.
  - READY: table complete.
- Shift rule: on cfg_load, table <= {cfg_bit, table[N-1:1]}. After N loads, the first bit loaded sits in table[0].
- Transitions:
  - UNCONF -> LOADING on cfg_load, with cnt <= 1.
  - LOADING stays in LOADING and increments cnt on each cfg_load. On the load that makes cnt = N, it goes to READY.
  - LOADING holds state and cnt while cfg_load = 0.
  - READY -> LOADING on cfg_load, with cnt <= 1. This is a reprogram, and the previous table contents are shifted out.
- Mux tree: level 0 uses N/2 muxes selected by index bit 0, and so on up to bit K-1; result = table[index].
- Data path:
  - in_valid is accepted only when state == READY and cfg_load == 0.
  - Accepted beat: out_data <= lane results and out_valid <= 1.
  - Otherwise out_valid <= 0 and out_data holds its last value.
- cfg_done = (state == READY); it is a registered state decode.
- Boundary conditions:
  - cfg_load and in_valid together in READY: the load wins, the beat is dropped (not buffered), and out_valid = 0 next cycle.
  - A beat accepted in the cycle before a reprogram still completes with the old table.
  - in_valid in UNCONF or LOADING is dropped silently.
  - rst mid-load: load is abandoned, cnt = 0, and the table takes its reset value.
  - No backpressure: the consumer must take every out_valid beat.
- Reset values: cnt = 0, out_valid = 0, out_data = 0. table, state and cfg_done are given under Configuration.

## Timing

- Data latency: 1 cycle. A beat accepted at edge t appears on out_data/out_valid after edge t (visible in cycle t+1).
- Throughput: one beat per cycle while in READY.
- Configuration: N cfg_load cycles (not necessarily consecutive). cfg_done rises in the cycle after the Nth load. The first data beat is accepted that same cycle.
- Reprogram: cfg_done falls in the cycle after the first cfg_load.
- Combinational depth: K mux levels plus the output register; no path runs from input to output without a register.

## Configuration

- Macro: LUT_CELL_AND_PRESET_EN.
- Defined:
  - Reset loads the K-input AND table: table = 1 << (N-1).
  - state = READY and cfg_done = 1 immediately after reset.
  - Data is accepted in the first cycle after reset.
- Undefined:
  - Reset gives table = 0, state = UNCONF and cfg_done = 0.
  - in_valid is ignored until a full table has been loaded.

## Test plan

- Macro undefined, K=2, W=4: reset, then in_valid=1 with in_data=16'hFFFF -> out_valid stays 0 and cfg_done=0.
- Load the AND table (shift 0,0,0,1), then send in_data=16'b11_10_01_00 -> cfg_done=1 one cycle after the 4th load; next cycle out_data=4'b1000, out_valid=1.
- Reprogram to XOR (shift 0,1,1,0) with the same in_data -> cfg_done drops one cycle after the first load; after reload, out_data=4'b0110.
- In READY, a beat in cycle t and cfg_load + in_valid in cycle t+1 -> beat t output uses the old table; beat t+1 is dropped (out_valid=0 in cycle t+2).
- Two of four bits loaded, then rst=1 for one cycle -> cnt=0, cfg_done=0, out_valid=0; a fresh 4-bit load is required.
- Macro defined: reset, then immediately in_data=16'b11_11_01_00 with in_valid=1 -> cfg_done=1 after reset; next cycle out_data=4'b1100.

Source files
------------

// File: rtl/lut_cell_using_mux_if.sv
// -----------------------------------------------------------------------------
// lut_cell_using_mux_if
//
// Bundles the configuration and data-path signals of lut_cell_using_mux.
//
// Parameters:
//   K : inputs per lane (truth table depth is 2^K)
//   W : number of lanes
//
// Signals:
//   cfg_load  : shift one truth-table bit this cycle          (master -> slave)
//   cfg_bit   : bit shifted in when cfg_load is high          (master -> slave)
//   cfg_done  : table complete, cell accepts data             (slave -> master)
//   in_valid  : in_data carries a beat this cycle             (master -> slave)
//   in_data   : lane j inputs at in_data[j*K +: K]            (master -> slave)
//   out_valid : out_data carries a result this cycle          (slave -> master)
//   out_data  : bit j = table[lane j index] of accepted beat  (slave -> master)
// -----------------------------------------------------------------------------
interface lut_cell_using_mux_if #(
    parameter int K = 2,
    parameter int W = 4
);
    logic           cfg_load;
    logic           cfg_bit;
    logic           cfg_done;
    logic           in_valid;
    logic [W*K-1:0] in_data;
    logic           out_valid;
    logic [W-1:0]   out_data;

    // Producer/consumer side: drives configuration and beats, observes results.
    modport master (
        output cfg_load,
        output cfg_bit,
        output in_valid,
        output in_data,
        input  cfg_done,
        input  out_valid,
        input  out_data
    );

    // Cell side.
    modport slave (
        input  cfg_load,
        input  cfg_bit,
        input  in_valid,
        input  in_data,
        output cfg_done,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/lut_cell_using_mux.sv
// -----------------------------------------------------------------------------
// lut_cell_using_mux
//
// Registered multi-lane programmable logic cell. A single 2^K-entry truth
// table is loaded serially and shared by W lanes; each lane looks up its
// K-bit index through a 2:1 mux tree. Results are registered, giving a
// one-cycle valid-qualified pipeline between producer and consumer.
//
// Parameters:
//   K : inputs per lane, 1..6 (N = 2^K table entries)
//   W : number of lanes
//
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : lut_cell_using_mux_if.slave (cfg_load/cfg_bit/cfg_done,
//         in_valid/in_data, out_valid/out_data)
//
// Build option:
//   LUT_CELL_AND_PRESET_EN : when defined, reset preloads the K-input AND
//   table and the cell comes out of reset READY. When undefined, reset
//   clears the table and a full serial load is needed before data flows.
// -----------------------------------------------------------------------------

// Per-lane lookup: K levels of 2:1 muxes, index bit l selecting at level l.
module lut_mux_tree #(
    parameter int K = 2
) (
    input  logic [(1<<K)-1:0] tbl_i,
    input  logic [K-1:0]      sel_i,
    output logic              y_o
);
    localparam int N = 1 << K;

    genvar l, i;
    for (l = 0; l < K; l++) begin : g_lvl
        // Level l reduces N>>l candidates to N>>(l+1).
        logic [(N>>(l+1))-1:0] q;
        for (i = 0; i < (N >> (l + 1)); i++) begin : g_mux
            if (l == 0) begin : g_leaf
                assign q[i] = sel_i[0] ? tbl_i[2*i+1] : tbl_i[2*i];
            end else begin : g_node
                assign q[i] = sel_i[l] ? g_lvl[l-1].q[2*i+1] : g_lvl[l-1].q[2*i];
            end
        end
    end

    assign y_o = g_lvl[K-1].q[0];
endmodule

module lut_cell_using_mux #(
    parameter int K = 2,
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    lut_cell_using_mux_if.slave  bus
);
    localparam int N  = 1 << K;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        UNCONF  = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } state_e;

`ifdef LUT_CELL_AND_PRESET_EN
    // Only the all-ones index yields 1: the K-input AND.
    localparam logic [N-1:0] RST_TBL   = {1'b1, {(N-1){1'b0}}};
    localparam state_e       RST_STATE = READY;
    localparam logic         RST_DONE  = 1'b1;
`else
    localparam logic [N-1:0] RST_TBL   = '0;
    localparam state_e       RST_STATE = UNCONF;
    localparam logic         RST_DONE  = 1'b0;
`endif

    state_e          state_q;
    logic [N-1:0]    tbl_q;
    logic [CW-1:0]   cnt_q;
    logic            cfg_done_q;

    logic [W-1:0]    lane_res;
    logic            accept;
    logic            out_valid_d, out_valid_q;
    logic [W-1:0]    out_data_d,  out_data_q;

    // -------------------------------------------------------------------------
    // Configuration FSM. Table shifts in from the top so the first bit loaded
    // ends up in entry 0 after N loads. cfg_done is decoded into a register
    // alongside the state so it never glitches.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RST_STATE;
            tbl_q      <= RST_TBL;
            cnt_q      <= '0;
            cfg_done_q <= RST_DONE;
        end else if (bus.cfg_load) begin
            tbl_q <= {bus.cfg_bit, tbl_q[N-1:1]};
            case (state_q)
                LOADING: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q    <= READY;
                        cfg_done_q <= 1'b1;
                    end
                end
                // UNCONF start, or READY reprogram: old contents shift out.
                default: begin
                    state_q    <= LOADING;
                    cnt_q      <= CNT_ONE;
                    cfg_done_q <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Lanes: one mux tree per lane, all reading the shared table.
    // -------------------------------------------------------------------------
    lut_mux_tree #(.K(K)) u_lane [W-1:0] (
        .tbl_i (tbl_q),
        .sel_i (bus.in_data),
        .y_o   (lane_res)
    );

    // -------------------------------------------------------------------------
    // Output stage. A load in the same cycle wins over a beat: the beat is
    // dropped rather than evaluated against a table that is mid-shift.
    // -------------------------------------------------------------------------
    assign accept = (state_q == READY) && !bus.cfg_load && bus.in_valid;

    always_comb begin
        out_valid_d = accept;
        out_data_d  = out_data_q;
        if (accept) begin
            out_data_d = lane_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.cfg_done  = cfg_done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule
